pong_match_ctrl: RTL and testbench

Match-level sequencer for the pong game. It decides when the ball is held at center, when it is served and in which direction, and when a rally ends. It also keeps both players' scores and declares a winner. It sits between the keyboard/start logic and the ball motion datapath: it consumes wall-hit events from the ball, and it drives hold, launch and serve-direction controls back to the ball.

---
 rtl/pong_pkg.sv | 16 +
 rtl/pong_frame_timer.sv | 16 +
 rtl/pong_match_ctrl.sv | 101 ++++++++++
 tb/tb_pong_match_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, winner codes and serve directions for the pong match logic
package pong_pkg;
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SERVE_WAIT = 3'd1,
      LAUNCH     = 3'd2,
      RALLY      = 3'd3,
      POINT      = 3'd4,
      GAME_OVER  = 3'd5
   } state_t;
   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1 = 2'b01;
   localparam logic [1:0] WIN_P2 = 2'b10;
   localparam logic DIR_LEFT = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;
endpackage

// File: rtl/pong_frame_timer.sv
// pong_frame_timer: counts frame ticks while enabled; done flags the tick that reaches SERVE_DELAY
module pong_frame_timer #(
   parameter int SERVE_DELAY = 60
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic tick_i,
   output logic done_o
);
   logic [7:0] cnt_q, cnt_d;
   // held at zero while disabled, so every entry into the serve wait starts from zero
   always_comb cnt_d = en_i ? cnt_q + 8'(tick_i) : '0;
   assign done_o = en_i && tick_i && (cnt_q == 8'(SERVE_DELAY - 1));
   always_ff @(posedge clk_i) cnt_q <= rst_ni ? cnt_d : '0;
endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer -- serve timing, rally end, scoring and winner for pong
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE = 10,
   parameter int SERVE_DELAY = 60,
   parameter int SCORE_W = 4
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               frame_tick,
   input  logic               start,
   input  logic               hit_left,
   input  logic               hit_right,
   output logic               ball_hold,
   output logic               ball_launch,
   output logic               serve_dir,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic [1:0]         winner,
   output logic [2:0]         state
);
   localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
   state_t state_q, state_d;
   logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
   logic [1:0] win_q, win_d;
   logic hold_q, hold_d, launch_q, launch_d, dir_q, dir_d, start_q, serve_done;
   pong_frame_timer #(.SERVE_DELAY(SERVE_DELAY)) u_timer (
      .clk_i (Clk),
      .rst_ni(Reset),
      .en_i  (state_q == SERVE_WAIT),
      .tick_i(frame_tick),
      .done_o(serve_done)
   );
   always_comb begin
      state_d = state_q;
      s1_d = s1_q;
      s2_d = s2_q;
      win_d = win_q;
      dir_d = dir_q;
      case (state_q)
         IDLE:       state_d = start ? SERVE_WAIT : IDLE;
         SERVE_WAIT: state_d = serve_done ? LAUNCH : SERVE_WAIT;
         LAUNCH:     state_d = RALLY;
         RALLY: begin
            // right wall wins a tie: the simultaneous left hit is dropped
            if (hit_right) begin
               s1_d = (s1_q < WIN) ? s1_q + SCORE_W'(1) : s1_q;
               dir_d = DIR_LEFT;
               state_d = POINT;
            end else if (hit_left) begin
               s2_d = (s2_q < WIN) ? s2_q + SCORE_W'(1) : s2_q;
               dir_d = DIR_RIGHT;
               state_d = POINT;
            end
         end
         POINT: begin
            win_d = (s1_q == WIN) ? WIN_P1 : (s2_q == WIN) ? WIN_P2 : WIN_NONE;
            state_d = (s1_q == WIN || s2_q == WIN) ? GAME_OVER : SERVE_WAIT;
         end
         GAME_OVER:  state_d = (start && !start_q) ? IDLE : GAME_OVER;
         default:    state_d = IDLE;
      endcase
      if (state_d == IDLE) begin
         s1_d = '0;
         s2_d = '0;
         win_d = WIN_NONE;
         dir_d = DIR_RIGHT;
      end
      hold_d = !(state_d inside {LAUNCH, RALLY});
      launch_d = state_d == LAUNCH;
   end
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_q <= IDLE;
         s1_q <= '0;
         s2_q <= '0;
         win_q <= WIN_NONE;
         hold_q <= 1'b1;
         launch_q <= 1'b0;
         dir_q <= DIR_RIGHT;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         s1_q <= s1_d;
         s2_q <= s2_d;
         win_q <= win_d;
         hold_q <= hold_d;
         launch_q <= launch_d;
         dir_q <= dir_d;
         start_q <= start;
      end
   end
   assign ball_hold = hold_q;
   assign ball_launch = launch_q;
   assign serve_dir = dir_q;
   assign score1 = s1_q;
   assign score2 = s2_q;
   assign winner = win_q;
   assign state = state_q;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed match scenarios; expected snapshots and launches are queued and checked by a monitor
module tb_pong_match_ctrl;
   import pong_pkg::*;
   typedef struct {
      int cyc;
      string nm;
      logic [2:0] st;
      logic [3:0] s1;
      logic [3:0] s2;
      logic [1:0] win;
      logic hold;
      logic launch;
      logic dir;
   } snap_t;
   typedef struct {
      int cyc;
      logic dir;
   } launch_t;
   logic Clk = 1'b0, Reset = 1'b0, frame_tick = 1'b0, start = 1'b0, hit_left = 1'b0, hit_right = 1'b0;
   logic ball_hold, ball_launch, serve_dir;
   logic [3:0] score1, score2;
   logic [1:0] winner;
   logic [2:0] state;
   int cyc = 0, n_vec = 0, n_bad = 0;
   logic fin = 1'b0, flushed = 1'b0;
   snap_t sq[$];
   launch_t lq[$];
   snap_t sx;
   launch_t lx;
   logic [13:0] act_v, exp_v;
   pong_match_ctrl #(.WIN_SCORE(4), .SERVE_DELAY(3), .SCORE_W(4)) dut (
      .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start),
      .hit_left(hit_left), .hit_right(hit_right), .ball_hold(ball_hold),
      .ball_launch(ball_launch), .serve_dir(serve_dir), .score1(score1),
      .score2(score2), .winner(winner), .state(state)
   );
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;
   always @(negedge Clk) begin
      if (ball_launch) begin
         n_vec++;
         if (lq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_launch cyc=%0d serve_dir=%b required no launch", cyc, serve_dir);
         end else begin
            lx = lq.pop_front();
            if (lx.cyc != cyc || lx.dir !== serve_dir) begin
               n_bad++;
               $display("FAIL launch got cyc=%0d dir=%b required cyc=%0d dir=%b", cyc, serve_dir, lx.cyc, lx.dir);
            end
         end
      end
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
         sx = sq.pop_front();
         n_vec++;
         act_v = {state, score1, score2, winner, ball_hold, ball_launch, serve_dir};
         exp_v = {sx.st, sx.s1, sx.s2, sx.win, sx.hold, sx.launch, sx.dir};
         if (sx.cyc != cyc || act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got st=%0d s1=%0d s2=%0d win=%b hold=%b launch=%b dir=%b required st=%0d s1=%0d s2=%0d win=%b hold=%b launch=%b dir=%b",
                     sx.nm, cyc, state, score1, score2, winner, ball_hold, ball_launch, serve_dir,
                     sx.st, sx.s1, sx.s2, sx.win, sx.hold, sx.launch, sx.dir);
         end
      end
      if (fin && !flushed) begin
         flushed = 1'b1;
         if (lq.size() + sq.size() != 0) begin
            n_bad += lq.size() + sq.size();
            $display("FAIL leftover got %0d launches and %0d snapshots unchecked required 0", lq.size(), sq.size());
         end
      end
   end
   task automatic step();
      @(posedge Clk);
      #1;
   endtask
   task automatic chk(string nm, state_t st, logic [3:0] a, logic [3:0] b, logic [1:0] w, logic h, logic l, logic d);
      sq.push_back('{cyc, nm, st, a, b, w, h, l, d});
   endtask
   task automatic serve(logic d, logic [3:0] a, logic [3:0] b);
      for (int i = 0; i < 3; i++) begin
         frame_tick = 1'b1;
         if (i == 2) lq.push_back('{cyc + 1, d});
         step();
         frame_tick = 1'b0;
         if (i < 2) begin
            chk("serve_wait", SERVE_WAIT, a, b, WIN_NONE, 1'b1, 1'b0, d);
            step();
         end
      end
      chk("launch", LAUNCH, a, b, WIN_NONE, 1'b0, 1'b1, d);
      step();
      chk("rally", RALLY, a, b, WIN_NONE, 1'b0, 1'b0, d);
   endtask
   task automatic hit(logic l, logic r, state_t st2, logic [3:0] a, logic [3:0] b, logic [1:0] w, logic d);
      hit_left = l;
      hit_right = r;
      step();
      hit_left = 1'b0;
      hit_right = 1'b0;
      chk("point", POINT, a, b, WIN_NONE, 1'b1, 1'b0, d);
      step();
      chk("after_point", st2, a, b, w, 1'b1, 1'b0, d);
   endtask
   initial begin
      step();
      step();
      chk("reset", IDLE, 0, 0, WIN_NONE, 1'b1, 1'b0, 1'b1);
      Reset = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("start", SERVE_WAIT, 0, 0, WIN_NONE, 1'b1, 1'b0, 1'b1);
      hit_left = 1'b1;
      step();
      hit_left = 1'b0;
      chk("hit_in_serve_wait", SERVE_WAIT, 0, 0, WIN_NONE, 1'b1, 1'b0, 1'b1);
      serve(1'b1, 0, 0);
      hit(1'b0, 1'b1, SERVE_WAIT, 1, 0, WIN_NONE, 1'b0);
      serve(1'b0, 1, 0);
      hit(1'b1, 1'b1, SERVE_WAIT, 2, 0, WIN_NONE, 1'b0);
      serve(1'b0, 2, 0);
      hit(1'b1, 1'b0, SERVE_WAIT, 2, 1, WIN_NONE, 1'b1);
      serve(1'b1, 2, 1);
      hit(1'b0, 1'b1, SERVE_WAIT, 3, 1, WIN_NONE, 1'b0);
      serve(1'b0, 3, 1);
      Reset = 1'b0;
      step();
      Reset = 1'b1;
      chk("reset_in_rally", IDLE, 0, 0, WIN_NONE, 1'b1, 1'b0, 1'b1);
      step();
      chk("idle_hold", IDLE, 0, 0, WIN_NONE, 1'b1, 1'b0, 1'b1);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart", SERVE_WAIT, 0, 0, WIN_NONE, 1'b1, 1'b0, 1'b1);
      serve(1'b1, 0, 0);
      hit(1'b1, 1'b0, SERVE_WAIT, 0, 1, WIN_NONE, 1'b1);
      serve(1'b1, 0, 1);
      hit(1'b1, 1'b0, SERVE_WAIT, 0, 2, WIN_NONE, 1'b1);
      serve(1'b1, 0, 2);
      hit(1'b1, 1'b0, SERVE_WAIT, 0, 3, WIN_NONE, 1'b1);
      serve(1'b1, 0, 3);
      start = 1'b1;
      hit(1'b1, 1'b0, GAME_OVER, 0, 4, WIN_P2, 1'b1);
      hit_left = 1'b1;
      hit_right = 1'b1;
      step();
      hit_left = 1'b0;
      hit_right = 1'b0;
      chk("hit_in_game_over", GAME_OVER, 0, 4, WIN_P2, 1'b1, 1'b0, 1'b1);
      step();
      chk("start_held", GAME_OVER, 0, 4, WIN_P2, 1'b1, 1'b0, 1'b1);
      start = 1'b0;
      step();
      chk("start_released", GAME_OVER, 0, 4, WIN_P2, 1'b1, 1'b0, 1'b1);
      start = 1'b1;
      step();
      chk("start_edge", IDLE, 0, 0, WIN_NONE, 1'b1, 1'b0, 1'b1);
      step();
      start = 1'b0;
      chk("idle_to_serve", SERVE_WAIT, 0, 0, WIN_NONE, 1'b1, 1'b0, 1'b1);
      step();
      fin = 1'b1;
      step();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
